cdb_unit_fifo: RTL and testbench
================================

// Module: cdb_unit_fifo
// PURPOSE
// Per-execution-unit result buffer sitting between one functional unit (ALU/MUL/DIV/BR/LD) and one of
// the five prioritized input slots of the central CDB arbiter FIFO. Holds completed results until the
// arbiter pops them, keeps each entry's EBR mask current on branch resolution, and squashes entries on
// the mispredicted path so the arbiter never sees them.
// PARAMETERS
// DEPTH        4   entries held; any value >= 2 (not restricted to powers of two)
// (cdb_t, EBR_MASK_SIZE come from rv32i_types / params packages)
// PORTS
// clk            in   1              clock
// rst            in   1              reset, synchronous, active-high
// enq            in   1              FU result valid this cycle
// wdata          in   cdb_t          FU result (valid, ebr_mask, tag, data, ...)
// ready          out  1              space available; FU may only assert enq when ready=1
// head_valid     out  1              entry available to arbiter (drives arbiter enqueue[i])
// rdata          out  cdb_t          head entry, raw stored value (drives arbiter wdata[i])
// deq            in   1              arbiter accepted head this cycle (arbiter dequeue_bb[i])
// bra_done       in   1              branch resolved this cycle
// bra_mispredict in   1              resolved branch mispredicted
// bra_id         in   EBR_MASK_SIZE  one-hot id of resolved branch
// BEHAVIOUR
// - Circular buffer: head (next pop), tail (next free), count 0..DEPTH ($clog2(DEPTH+1) bits);
//   head/tail wrap DEPTH-1 -> 0 explicitly.
// - Reset: all entries '0, head=tail=count=0 -> ready=1, head_valid=0, rdata='0.
// - ready = (count != DEPTH), combinational from count. enq while full is ignored (no write, no error).
// - head_valid = (count != 0) && queue[head].valid. rdata = queue[head] regardless of head_valid.
// - EBR resolution uses ebr_resolve per stored entry and one on wdata:
//   out_mask = in_mask & ~bra_id; invalid = bra_mispredict && |(in_mask & bra_id).
// - On bra_done: every stored entry takes out_mask; entries with invalid get valid<=0 (slot kept).
// - Enqueue (enq && ready): wdata written at tail, tail++, count++. If bra_done same cycle, the written
//   mask is resolved; if resolved invalid, the write is dropped entirely (no tail/count change).
// - Pop: occurs when count!=0 and either (deq && head_valid) or head entry valid=0 (auto-drain of
//   squashed slot, at most one slot per cycle). Pop clears queue[head].valid, head++, count--.
// - deq while head_valid=0 is ignored (an auto-drain may still occur).
// - Arbiter filters its own inputs on bra_done and will not assert deq for a head that goes invalid
//   that cycle; this block squashes that head in the same cycle, so arbiter and this FIFO stay consistent.
// - Simultaneous enq and pop: both take effect; count unchanged. Allowed at count=DEPTH? No: ready=0
//   when full, even if a pop happens that cycle (no same-cycle bypass of fullness).
// - Empty: enq data is not forwarded combinationally; earliest head_valid is the cycle after enq.
// - Latency: enq in cycle N -> head_valid in cycle N+1 (if empty). Pop visible cycle after deq.
// - Squash on enq and on-head auto-drain both apply in the same cycle; stored entries behind head stay
//   in place as valid=0 until they reach head.
// - rst mid-operation: all state cleared next edge, in-flight enq/deq that cycle discarded.
// TESTING
// 1 Reset then 4 enq (tags 1..4), no deq -> ready=0 after 4th, head_valid=1, rdata.tag=1, 5th enq dropped.
// 2 Full FIFO, deq each cycle for 4 cycles -> tags 1,2,3,4 in order, then head_valid=0, count=0, ready=1.
// 3 Entries masks 4'b0001,4'b0010,4'b0001; bra_done, mispredict, bra_id=4'b0001 -> entries 0,2 squashed,
//   auto-drained; arbiter sees only tag of entry 1, mask 4'b0010.
// 4 Same pattern with bra_mispredict=0 -> all 3 delivered, masks 4'b0000,4'b0010,4'b0000.
// 5 enq of mask 4'b0100 in same cycle as bra_done/mispredict id 4'b0100 -> not written, count unchanged;
//   mask 4'b1000 same cycle -> written with mask 4'b1000.
// 6 count=2 at wrap (head=3,tail=1, DEPTH=4), enq+deq same cycle x6 -> order preserved, count stays 2.

Source files
------------

// File: rtl/cdb_unit_fifo.sv
// Per-FU result buffer feeding one CDB arbiter input slot.
// Tracks branch resolution on stored results and drains squashed slots.
package params;
    parameter int EBR_MASK_SIZE = 4;
endpackage

package rv32i_types;
    import params::*;

    typedef struct packed {
        logic                     valid;
        logic [EBR_MASK_SIZE-1:0] ebr_mask;
        logic [5:0]               tag;
        logic [31:0]              data;
    } cdb_t;
endpackage

module cdb_unit_fifo
    import params::*;
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq,
    input  cdb_t                     wdata,
    output logic                     ready,
    output logic                     head_valid,
    output cdb_t                     rdata,
    input  logic                     deq,
    input  logic                     bra_done,
    input  logic                     bra_mispredict,
    input  logic [EBR_MASK_SIZE-1:0] bra_id
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    cdb_t          queue [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    cdb_t wr_data;
    cdb_t head_entry;
    logic wr_drop;
    logic push;
    logic pop;

    function automatic cdb_t ebr_resolve(input cdb_t e);
        cdb_t r;
        r = e;
        r.ebr_mask = e.ebr_mask & ~bra_id;
        if (bra_mispredict && |(e.ebr_mask & bra_id)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        head_entry = queue[head];
        ready      = (count != CW'(DEPTH));
        head_valid = (count != '0) && head_entry.valid;
        rdata      = head_entry;
        // a squashed head slot drains on its own, one per cycle
        pop        = (count != '0) && (!head_entry.valid || deq);
        wr_data    = bra_done ? ebr_resolve(wdata) : wdata;
        wr_drop    = bra_done && bra_mispredict && |(wdata.ebr_mask & bra_id);
        push       = enq && ready && !wr_drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                queue[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (bra_done) begin
                for (int i = 0; i < DEPTH; i++) begin
                    queue[i] <= ebr_resolve(queue[i]);
                end
            end
            if (pop) begin
                queue[head].valid <= 1'b0;
                head              <= ptr_inc(head);
            end
            if (push) begin
                queue[tail] <= wr_data;
                tail        <= ptr_inc(tail);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_cdb_unit_fifo.sv
// Bench for cdb_unit_fifo: directed scenarios plus random traffic
// checked against a queue-based model of the buffer.
module tb_cdb_unit_fifo;
    import params::*;
    import rv32i_types::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enq;
    cdb_t       wdata;
    logic       ready;
    logic       head_valid;
    cdb_t       rdata;
    logic       deq;
    logic       bra_done;
    logic       bra_mispredict;
    logic [3:0] bra_id;

    int checks = 0;
    int errors = 0;

    cdb_t mq[$];

    cdb_unit_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .enq(enq),
        .wdata(wdata),
        .ready(ready),
        .head_valid(head_valid),
        .rdata(rdata),
        .deq(deq),
        .bra_done(bra_done),
        .bra_mispredict(bra_mispredict),
        .bra_id(bra_id)
    );

    always #5 clk = ~clk;

    function automatic cdb_t mk(input logic [5:0] tag, input logic [3:0] mask);
        cdb_t e;
        e.valid    = 1'b1;
        e.ebr_mask = mask;
        e.tag      = tag;
        e.data     = $urandom;
        return e;
    endfunction

    function automatic bit m_ready();
        return mq.size() != DEPTH;
    endfunction

    function automatic bit m_hv();
        return mq.size() != 0 && mq[0].valid;
    endfunction

    // One clock: model follows the slot-level rules, then inputs go idle.
    task automatic tick();
        bit   pop;
        bit   room;
        bit   kill;
        cdb_t e;
        pop  = mq.size() != 0 && ((deq && mq[0].valid) || !mq[0].valid);
        room = m_ready();
        @(posedge clk);
        if (rst) begin
            mq.delete();
        end else begin
            if (bra_done) begin
                foreach (mq[i]) begin
                    e = mq[i];
                    if (bra_mispredict && (e.ebr_mask & bra_id) != 0) e.valid = 1'b0;
                    e.ebr_mask = e.ebr_mask & ~bra_id;
                    mq[i] = e;
                end
            end
            if (pop) void'(mq.pop_front());
            if (enq && room) begin
                e    = wdata;
                kill = 1'b0;
                if (bra_done) begin
                    kill = bra_mispredict && (e.ebr_mask & bra_id) != 0;
                    e.ebr_mask = e.ebr_mask & ~bra_id;
                end
                if (!kill) mq.push_back(e);
            end
        end
        #1;
        enq            = 1'b0;
        deq            = 1'b0;
        bra_done       = 1'b0;
        bra_mispredict = 1'b0;
        bra_id         = '0;
        wdata          = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", ready);
        end
        checks++;
        if (head_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hv got=%b exp=0", head_valid);
        end
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata got=%h exp=0", rdata);
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 5; i++) begin
            enq   = 1'b1;
            wdata = mk(6'(i), 4'b0000);
            tick();
        end
        checks++;
        if (ready !== 1'b0 || head_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_flags got=%b%b exp=01", ready, head_valid);
        end
        checks++;
        if (rdata.tag !== 6'd1) begin
            errors++;
            $display("FAIL fill_head_tag got=%0d exp=1", rdata.tag);
        end
        checks++;
        if (mq.size() != 4 || mq[3].tag != 6'd4) begin
            errors++;
            $display("FAIL fill_model size=%0d exp=4", mq.size());
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (head_valid !== 1'b1 || rdata.tag !== 6'(i)) begin
                errors++;
                $display("FAIL drain_order got hv=%b tag=%0d exp hv=1 tag=%0d", head_valid, rdata.tag, i);
            end
            deq = 1'b1;
            tick();
        end
        checks++;
        if (head_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got hv=%b rdy=%b exp hv=0 rdy=1", head_valid, ready);
        end
    endtask

    task automatic load3(input logic [5:0] t0);
        enq = 1'b1; wdata = mk(t0, 4'b0001); tick();
        enq = 1'b1; wdata = mk(t0 + 6'd1, 4'b0010); tick();
        enq = 1'b1; wdata = mk(t0 + 6'd2, 4'b0001); tick();
    endtask

    task automatic test_squash();
        load3(6'd10);
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0001;
        tick();
        checks++;
        if (head_valid !== 1'b0) begin
            errors++;
            $display("FAIL squash_head got hv=%b exp=0", head_valid);
        end
        tick();
        checks++;
        if (head_valid !== 1'b1 || rdata.tag !== 6'd11 || rdata.ebr_mask !== 4'b0010) begin
            errors++;
            $display("FAIL squash_survivor got hv=%b tag=%0d mask=%b exp hv=1 tag=11 mask=0010",
                     head_valid, rdata.tag, rdata.ebr_mask);
        end
        deq = 1'b1;
        tick();
        tick();
        checks++;
        if (head_valid !== 1'b0 || ready !== 1'b1 || mq.size() != 0) begin
            errors++;
            $display("FAIL squash_drain got hv=%b rdy=%b exp hv=0 rdy=1", head_valid, ready);
        end
    endtask

    task automatic test_resolve();
        logic [3:0] exp_mask [3];
        exp_mask = '{4'b0000, 4'b0010, 4'b0000};
        load3(6'd20);
        bra_done = 1'b1; bra_mispredict = 1'b0; bra_id = 4'b0001;
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (head_valid !== 1'b1 || rdata.tag !== 6'(20 + i) || rdata.ebr_mask !== exp_mask[i]) begin
                errors++;
                $display("FAIL resolve_entry%0d got hv=%b tag=%0d mask=%b exp tag=%0d mask=%b",
                         i, head_valid, rdata.tag, rdata.ebr_mask, 20 + i, exp_mask[i]);
            end
            deq = 1'b1;
            tick();
        end
    endtask

    task automatic test_enq_resolve();
        enq = 1'b1; wdata = mk(6'd30, 4'b0100);
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0100;
        tick();
        checks++;
        if (head_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL enq_squash got hv=%b rdy=%b exp hv=0 rdy=1", head_valid, ready);
        end
        enq = 1'b1; wdata = mk(6'd31, 4'b1000);
        bra_done = 1'b1; bra_mispredict = 1'b1; bra_id = 4'b0100;
        tick();
        checks++;
        if (head_valid !== 1'b1 || rdata.tag !== 6'd31 || rdata.ebr_mask !== 4'b1000) begin
            errors++;
            $display("FAIL enq_keep got hv=%b tag=%0d mask=%b exp hv=1 tag=31 mask=1000",
                     head_valid, rdata.tag, rdata.ebr_mask);
        end
        deq = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq = 1'b1; wdata = mk(6'(40 + i), 4'b0000); tick();
        end
        for (int i = 0; i < 3; i++) begin
            deq = 1'b1; tick();
        end
        enq = 1'b1; wdata = mk(6'd50, 4'b0000); tick();
        enq = 1'b1; wdata = mk(6'd51, 4'b0000); tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (head_valid !== 1'b1 || rdata.tag !== 6'(50 + i) || ready !== 1'b1) begin
                errors++;
                $display("FAIL wrap_step%0d got hv=%b tag=%0d rdy=%b exp tag=%0d",
                         i, head_valid, rdata.tag, ready, 50 + i);
            end
            enq = 1'b1; deq = 1'b1; wdata = mk(6'(52 + i), 4'b0000);
            tick();
        end
        checks++;
        if (mq.size() != 2 || rdata.tag !== 6'd56) begin
            errors++;
            $display("FAIL wrap_end got tag=%0d size=%0d exp tag=56 size=2", rdata.tag, mq.size());
        end
    endtask

    task automatic test_random();
        int k;
        for (int c = 0; c < 600; c++) begin
            checks++;
            if (ready !== m_ready() || head_valid !== m_hv()) begin
                errors++;
                $display("FAIL rand_flags cyc=%0d got rdy=%b hv=%b exp rdy=%b hv=%b",
                         c, ready, head_valid, m_ready(), m_hv());
            end
            if (m_hv()) begin
                checks++;
                if (rdata !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", c, rdata, mq[0]);
                end
            end
            rst   = ($urandom_range(0, 99) == 0);
            enq   = ($urandom_range(0, 2) != 0);
            wdata = mk(6'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                k              = $urandom_range(0, 3);
                bra_done       = 1'b1;
                bra_mispredict = $urandom_range(0, 1);
                bra_id         = 4'b0001 << k;
            end
            deq = m_hv() && ($urandom_range(0, 2) != 0);
            if (deq && bra_done && bra_mispredict && (mq[0].ebr_mask & bra_id) != 0) deq = 1'b0;
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enq = 1'b0; deq = 1'b0; wdata = '0;
        bra_done = 1'b0; bra_mispredict = 1'b0; bra_id = '0;
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_squash();
        test_resolve();
        test_enq_resolve();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
